// File: rtl/lfsr_pkg.sv
// Shared encodings for the LFSR generator: FSM states, config targets, step mode.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_LOCKUP = 2'b10
    } fsm_t;

    typedef enum logic {
        MODE_FIB    = 1'b0,
        MODE_GALOIS = 1'b1
    } mode_t;

    // cfg_sel targets; code 2'b11 is reserved and ignored
    localparam logic [1:0] CFG_SEED = 2'b00;
    localparam logic [1:0] CFG_TAPS = 2'b01;
    localparam logic [1:0] CFG_MODE = 2'b10;

endpackage

// File: rtl/lfsr_gen_step.sv
// Combinational LFSR advance: one Fibonacci or Galois step from the current state.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] state,
    input  logic [N-1:0] taps,
    input  mode_t        mode,
    output logic [N-1:0] next_state
);

    // Fibonacci feeds the tap parity into bit 0; Galois folds the taps in when the MSB shifts out
    always_comb begin
        next_state = {state[N-2:0], ^(state & taps)};
        if (mode == MODE_GALOIS) begin
            next_state = {state[N-2:0], 1'b0} ^ ({N{state[N-1]}} & taps);
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR with serial config, ready/valid output,
// all-zero lockup detection and period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int           N         = 16,
    parameter logic [N-1:0] SEED_INIT = N'(1),
    parameter logic [N-1:0] TAP_INIT  = N'(16'hB400)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   cfg_sel,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    input  logic         start,
    input  logic         stop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic [N-1:0] out_word,
    output logic         lockup,
    output logic         period_valid,
    output logic [N-1:0] period
);

    fsm_t         fsm_q, fsm_d;
    mode_t        mode_q;
    logic [N-1:0] lfsr_q;
    logic [N-1:0] seed_q;
    logic [N-1:0] taps_q;
    logic [N-1:0] count_q;
    logic [N-1:0] period_q;
    logic         period_valid_q;
    logic [N-1:0] next_state;
    logic         step;
    logic         cfg_fire;
    logic         load;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
        return (&v) ? v : v + N'(1);
    endfunction

    lfsr_step #(.N(N)) u_step (
        .state      (lfsr_q),
        .taps       (taps_q),
        .mode       (mode_q),
        .next_state (next_state)
    );

    // stop beats both a same-cycle start and a same-cycle step
    assign step     = out_valid & out_ready & ~stop;
    assign cfg_fire = cfg_valid & cfg_ready;
    assign load     = (fsm_q == ST_IDLE) & start & ~stop & (seed_q != '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) fsm_q <= ST_IDLE;
        else       fsm_q <= fsm_d;
    end

    // FSM next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (!stop && start) fsm_d = (seed_q != '0) ? ST_RUN : ST_LOCKUP;
            end
            ST_RUN: begin
                if (stop)                                fsm_d = ST_IDLE;
                else if (out_ready && next_state == '0)  fsm_d = ST_LOCKUP;
            end
            ST_LOCKUP: begin
                if (stop || start) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        out_valid = (fsm_q == ST_RUN);
        lockup    = (fsm_q == ST_LOCKUP);
        cfg_ready = (fsm_q == ST_IDLE);
    end

    // Config shift registers, LFSR state, step counter and period capture
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q         <= '0;
            seed_q         <= SEED_INIT;
            taps_q         <= TAP_INIT;
            mode_q         <= MODE_FIB;
            count_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (cfg_fire) begin
                case (cfg_sel)
                    CFG_SEED: seed_q <= {seed_q[N-2:0], cfg_bit};
                    CFG_TAPS: taps_q <= {taps_q[N-2:0], cfg_bit};
                    CFG_MODE: mode_q <= mode_t'(cfg_bit);
                    default:  ;
                endcase
            end
            if (load) begin
                lfsr_q  <= seed_q;
                count_q <= '0;
            end else if (step) begin
                lfsr_q <= next_state;
                if (next_state == seed_q) begin
                    period_q       <= sat_inc(count_q);
                    period_valid_q <= 1'b1;
                    count_q        <= '0;
                end else begin
                    count_q <= sat_inc(count_q);
                end
            end
        end
    end

    assign out_word     = lfsr_q;
    assign out_bit      = lfsr_q[N-1];
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter N, default 16, SHALL set the LFSR width, legal range 4..32.
REQ-002 Parameter SEED_INIT, default 1, SHALL be the seed register value after reset.
REQ-003 Parameter TAP_INIT, default 16'hB400, SHALL be the tap register value after reset.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_sel  in  2  config target: 00 seed, 01 taps, 10 mode (bit0: 0 Fibonacci, 1 Galois), 11 reserved (ignored).
REQ-007 cfg_valid  in  1  cfg_bit is offered.
REQ-008 cfg_bit  in  1  serial config data.
REQ-009 cfg_ready  out  1  config accepted this cycle when cfg_valid&cfg_ready.
REQ-010 start  in  1  single-cycle request to load the seed into state and run.
REQ-011 stop  in  1  single-cycle request to return to IDLE.
REQ-012 out_valid  out  1  out_bit/out_word hold a valid step.
REQ-013 out_ready  in  1  consumer accepts the step; state advances on out_valid&out_ready.
REQ-014 out_bit  out  1  state[N-1] (current state, pre-advance).
REQ-015 out_word  out  N  current LFSR state.
REQ-016 lockup  out  1  high while in LOCKUP.
REQ-017 period_valid  out  1  one-cycle pulse when the state returns to the seed.
REQ-018 period  out  N  steps since start or last period_valid, saturating at all-ones; held until the next pulse.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and LOCKUP.
REQ-020 cfg_ready SHALL be 1 only in IDLE; in RUN and LOCKUP config handshakes SHALL be ignored.
REQ-021 An accepted seed/tap bit SHALL shift in MSB-first: reg <= {reg[N-2:0], cfg_bit}; mode SHALL load cfg_bit directly.
REQ-022 IDLE->RUN on start with seed!=0: state<=seed, cycle counter<=0; IDLE->LOCKUP on start with seed==0.
REQ-023 RUN->IDLE on stop; stop SHALL take priority over start and over a same-cycle step.
REQ-024 out_valid SHALL be 1 in RUN only; out_word/out_bit SHALL be stable while out_valid&!out_ready.
REQ-025 Fibonacci step: state <= {state[N-2:0], ^(state&taps)}.
REQ-026 Galois step: state <= {state[N-2:0],1'b0} ^ ({N{state[N-1]}} & taps).
REQ-027 A step whose next state is all-zero SHALL commit and move RUN->LOCKUP in the same edge.
REQ-028 LOCKUP SHALL exit to IDLE on stop or start; start in LOCKUP SHALL NOT re-run.
REQ-029 The cycle counter SHALL increment per accepted step; when the next state equals seed, period<=counter+1, period_valid pulses, counter<=0.
REQ-030 Counter SHALL saturate at 2^N-1 and not wrap.
REQ-031 Output latency: a step accepted at edge k SHALL show the new out_word after edge k.

Reset
REQ-032 Reset SHALL force IDLE, state=0, seed=SEED_INIT, taps=TAP_INIT, mode=Fibonacci, counter=0, period=0.
REQ-033 After reset: out_valid=0, lockup=0, period_valid=0, cfg_ready=1, out_word=0, out_bit=0; reset mid-RUN SHALL abandon the sequence with no further output.

Structure
REQ-034 Package lfsr_pkg SHALL hold the FSM state encoding, cfg_sel codes and mode encoding.
REQ-035 Sub-module lfsr_step (combinational next-state from state, taps, mode) SHALL be instantiated once.

Verification
REQ-036 N=8, Fibonacci, taps 0xB8, seed 0x01, start, out_ready=1 -> out_word 0x01,0x02,0x04,...; period_valid after 255 steps, period=255.
REQ-037 N=8, Galois, taps 0x1D, seed 0x01 -> out_word after 8 steps = 0x1D; period=255.
REQ-038 out_ready=0 for 5 cycles in RUN -> out_word frozen; cycle counter unchanged.
REQ-039 Seed 0x00 then start -> lockup=1, out_valid=0; start ignored; stop -> IDLE, cfg_ready=1.
REQ-040 start+stop same cycle in IDLE -> stays IDLE; stop+step in RUN -> IDLE, state not advanced.
REQ-041 Reset asserted mid-RUN -> next cycle out_valid=0, seed=SEED_INIT, taps=TAP_INIT, period=0.
